// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: 16x16 data memory with store/load, a registered
// write-back bundle, a combinational debug read port, a sticky conflict flag and a store counter.
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result_in,
    input  logic [3:0]  reg_addr_in,
    input  logic [3:0]  mem_addr_in,
    input  logic        write_enable_in,
    input  logic        store_enable_in,
    input  logic        load_enable_in,
    input  logic        stall_in,
    input  logic [3:0]  dbg_addr_in,
    output logic [15:0] wb_data_out,
    output logic [3:0]  wb_reg_addr_out,
    output logic        wb_write_enable_out,
    output logic [15:0] dbg_data_out,
    output logic        conflict_err_out,
    output logic [7:0]  store_count_out
);

    logic [15:0] mem_q [16];

    logic [15:0] wb_data_q, wb_data_d;
    logic [3:0]  wb_reg_q;
    logic        wb_we_q;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        store_go;
    logic        load_go;

    always_comb begin
        store_go  = !stall_in && store_enable_in;
        // A store wins over a simultaneous load; the load is dropped.
        load_go   = load_enable_in && !store_enable_in;
        wb_data_d = load_go ? mem_q[mem_addr_in] : result_in;
        cnt_d     = (store_go && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
        err_d     = err_q | (!stall_in && store_enable_in && load_enable_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data_q <= 16'h0000;
            wb_reg_q  <= 4'h0;
            wb_we_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 8'h00;
        end else if (!stall_in) begin
            wb_data_q <= wb_data_d;
            wb_reg_q  <= reg_addr_in;
            wb_we_q   <= write_enable_in;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Memory is a flop array so every word can be cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (store_go) begin
            mem_q[mem_addr_in] <= result_in;
        end
    end

    assign wb_data_out         = wb_data_q;
    assign wb_reg_addr_out     = wb_reg_q;
    assign wb_write_enable_out = wb_we_q;
    assign conflict_err_out    = err_q;
    assign store_count_out     = cnt_q;
    assign dbg_data_out        = mem_q[dbg_addr_in];

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: behavioural model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] result_in = '0;
    logic [3:0]  reg_addr_in = '0;
    logic [3:0]  mem_addr_in = '0;
    logic        write_enable_in = 1'b0;
    logic        store_enable_in = 1'b0;
    logic        load_enable_in = 1'b0;
    logic        stall_in = 1'b0;
    logic [3:0]  dbg_addr_in = '0;
    logic [15:0] wb_data_out;
    logic [3:0]  wb_reg_addr_out;
    logic        wb_write_enable_out;
    logic [15:0] dbg_data_out;
    logic        conflict_err_out;
    logic [7:0]  store_count_out;

    mem_access_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .result_in           (result_in),
        .reg_addr_in         (reg_addr_in),
        .mem_addr_in         (mem_addr_in),
        .write_enable_in     (write_enable_in),
        .store_enable_in     (store_enable_in),
        .load_enable_in      (load_enable_in),
        .stall_in            (stall_in),
        .dbg_addr_in         (dbg_addr_in),
        .wb_data_out         (wb_data_out),
        .wb_reg_addr_out     (wb_reg_addr_out),
        .wb_write_enable_out (wb_write_enable_out),
        .dbg_data_out        (dbg_data_out),
        .conflict_err_out    (conflict_err_out),
        .store_count_out     (store_count_out)
    );

    always #20 clk = ~clk;

    // Behavioural model of the architectural state.
    logic [15:0] m_mem [16];
    logic [15:0] m_wb;
    logic [3:0]  m_ra;
    logic        m_we;
    logic        m_err;
    int          m_cnt;

    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
        m_wb = 16'h0; m_ra = 4'h0; m_we = 1'b0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step(input logic st, input logic ld, input logic stl,
                              input logic [15:0] res, input logic [3:0] ra,
                              input logic [3:0] ma, input logic we);
        if (stl) return;
        m_wb = (ld && !st) ? m_mem[ma] : res;
        if (st) begin
            m_mem[ma] = res;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        if (st && ld) m_err = 1'b1;
        m_ra = ra;
        m_we = we;
    endtask

    task automatic check_all();
        cmp("wb_data", wb_data_out, m_wb);
        cmp("wb_reg_addr", {12'h0, wb_reg_addr_out}, {12'h0, m_ra});
        cmp("wb_we", {15'h0, wb_write_enable_out}, {15'h0, m_we});
        cmp("conflict_err", {15'h0, conflict_err_out}, {15'h0, m_err});
        cmp("store_count", {8'h0, store_count_out}, m_cnt[15:0]);
        cmp("dbg_data", dbg_data_out, m_mem[dbg_addr_in]);
    endtask

    // Sweeps every debug address; zero=1 demands literal zeros.
    task automatic sweep_dbg(input bit zero);
        for (int a = 0; a < 16; a++) begin
            dbg_addr_in = a[3:0];
            #1;
            cmp(zero ? "dbg_zero" : "dbg_sweep", dbg_data_out, zero ? 16'h0 : m_mem[a]);
        end
    endtask

    task automatic peek(input logic [3:0] a, input logic [15:0] exp);
        dbg_addr_in = a;
        #1;
        cmp("dbg_lit", dbg_data_out, exp);
    endtask

    task automatic cyc(input logic st, input logic ld, input logic stl,
                       input logic [15:0] res, input logic [3:0] ra,
                       input logic [3:0] ma, input logic we);
        store_enable_in = st; load_enable_in = ld; stall_in = stl;
        result_in = res; reg_addr_in = ra; mem_addr_in = ma; write_enable_in = we;
        dbg_addr_in = ncyc[3:0];
        ncyc++;
        @(posedge clk);
        model_step(st, ld, stl, res, ra, ma, we);
        @(negedge clk);
        check_all();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; a store held during reset must be discarded.
    task automatic do_reset();
        reset = 1'b1;
        store_enable_in = 1'b1; load_enable_in = 1'b1; stall_in = 1'b0;
        result_in = 16'hFFFF; mem_addr_in = 4'h9; reg_addr_in = 4'hF; write_enable_in = 1'b1;
        model_reset();
        #1;
        cmp("rst_wb_data", wb_data_out, 16'h0);
        cmp("rst_wb_reg", {12'h0, wb_reg_addr_out}, 16'h0);
        cmp("rst_wb_we", {15'h0, wb_write_enable_out}, 16'h0);
        cmp("rst_err", {15'h0, conflict_err_out}, 16'h0);
        cmp("rst_count", {8'h0, store_count_out}, 16'h0);
        sweep_dbg(1'b1);
        @(posedge clk);
        #1;
        peek(4'h9, 16'h0);
        check_all();
        @(negedge clk);
        #1;
        reset = 1'b0;
        store_enable_in = 1'b0; load_enable_in = 1'b0;
        write_enable_in = 1'b0; result_in = 16'h0;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // Store BEEF at 3, then load it back to register 5.
        cyc(1'b1, 1'b0, 1'b0, 16'hBEEF, 4'h0, 4'h3, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 4'h5, 4'h3, 1'b1);
        cmp("lit_load_data", wb_data_out, 16'hBEEF);
        cmp("lit_load_reg", {12'h0, wb_reg_addr_out}, 16'h5);
        cmp("lit_load_we", {15'h0, wb_write_enable_out}, 16'h1);
        cmp("lit_load_count", {8'h0, store_count_out}, 16'h1);

        // Pass-through on a freshly cleared memory.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 16'h1234, 4'h7, 4'h6, 1'b1);
        cmp("lit_pass_data", wb_data_out, 16'h1234);
        cmp("lit_pass_reg", {12'h0, wb_reg_addr_out}, 16'h7);
        sweep_dbg(1'b1);

        // Back-to-back store/load on one address, load from unwritten word, load with we=0.
        cyc(1'b1, 1'b0, 1'b0, 16'hCAFE, 4'h1, 4'hA, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'h7777, 4'h2, 4'hA, 1'b0);
        cmp("lit_fwd_data", wb_data_out, 16'hCAFE);
        cyc(1'b0, 1'b1, 1'b0, 16'h8888, 4'h3, 4'hB, 1'b1);
        cmp("lit_empty_load", wb_data_out, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0F0F, 4'h4, 4'hB, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'hF0F0, 4'h5, 4'hA, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 4'h6, 4'hB, 1'b1);
        cmp("lit_load_b", wb_data_out, 16'h0F0F);
        sweep_dbg(1'b0);

        // Conflict: store wins, load suppressed, error sticks.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 16'h00AA, 4'h8, 4'h2, 1'b1);
        cmp("lit_conf_data", wb_data_out, 16'h00AA);
        cmp("lit_conf_err", {15'h0, conflict_err_out}, 16'h1);
        peek(4'h2, 16'h00AA);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, i[0], 1'b0, 16'(i * 3), i[3:0], 4'h2, ~i[0]);
        end
        cmp("lit_conf_sticky", {15'h0, conflict_err_out}, 16'h1);

        // Stall holds everything and blocks the store until release.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 16'h4321, 4'hC, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 16'h5555, 4'h9, 4'h4, 1'b0);
        end
        peek(4'h4, 16'h0000);
        cmp("lit_stall_count", {8'h0, store_count_out}, 16'h0);
        cmp("lit_stall_data", wb_data_out, 16'h4321);
        cmp("lit_stall_reg", {12'h0, wb_reg_addr_out}, 16'hC);
        cyc(1'b1, 1'b0, 1'b0, 16'h5555, 4'h9, 4'h4, 1'b0);
        peek(4'h4, 16'h5555);
        cmp("lit_release_count", {8'h0, store_count_out}, 16'h1);

        // Counter saturation over 300 stores, then an async reset mid-cycle.
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'(i + 16'h100), i[3:0], i[3:0], i[1]);
        end
        cmp("lit_sat_count", {8'h0, store_count_out}, 16'h00FF);
        sweep_dbg(1'b0);
        store_enable_in = 1'b0;
        @(posedge clk);
        #2;
        do_reset();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
